// File: rtl/regfile_arbiter_if.sv
// Requester-side and register-file-side bus of the register file arbiter.
// The slave modport is the arbiter's view; master is the requesters plus register file.
interface regfile_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    wr;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               err;
  logic               rf_wen;
  logic               rf_oen;
  logic [AW-1:0]      rf_addr;
  logic [DW-1:0]      rf_din;
  logic [DW-1:0]      rf_dout;

  modport slave (
    input  req, wr, addr, wdata, rf_dout,
    output gnt, rvalid, rdata, err, rf_wen, rf_oen, rf_addr, rf_din
  );

  modport master (
    output req, wr, addr, wdata, rf_dout,
    input  gnt, rvalid, rdata, err, rf_wen, rf_oen, rf_addr, rf_din
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port register file bus among NREQ requesters.
// One transaction at a time: grant+issue, then (reads only) a wait cycle before returning data.
module regfile_arbiter #(
  parameter int NREQ  = 4,
  parameter int NREGS = 7,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  regfile_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   last_reg, last_next;
  logic [IW-1:0]   win_reg, win_next;
  logic            wr_reg, wr_next;
  logic            ill_reg, ill_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] rvalid_reg, rvalid_next;
  logic [DW-1:0]   rdata_reg, rdata_next;
  logic            err_reg, err_next;
  logic            rf_wen_reg, rf_wen_next;
  logic            rf_oen_reg, rf_oen_next;
  logic [AW-1:0]   rf_addr_reg, rf_addr_next;
  logic [DW-1:0]   rf_din_reg, rf_din_next;

  logic [AW-1:0]   addr_slice  [NREQ];
  logic [DW-1:0]   wdata_slice [NREQ];
  logic [IW-1:0]   win_idx;
  logic            illegal;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_slice[gi]  = bus.addr[gi*AW +: AW];
      assign wdata_slice[gi] = bus.wdata[gi*DW +: DW];
    end
  endgenerate

  // Search starts one past the last winner so every requester gets its turn.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    win_idx = last_reg;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_reg) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  assign illegal = (int'(addr_slice[win_idx]) >= NREGS);

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    win_next     = win_reg;
    wr_next      = wr_reg;
    ill_next     = ill_reg;
    gnt_next     = '0;
    rvalid_next  = '0;
    rdata_next   = rdata_reg;
    err_next     = 1'b0;
    rf_wen_next  = 1'b0;
    rf_oen_next  = 1'b0;
    rf_addr_next = rf_addr_reg;
    rf_din_next  = rf_din_reg;

    case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          state_next        = ISSUE;
          last_next         = win_idx;
          win_next          = win_idx;
          wr_next           = bus.wr[win_idx];
          ill_next          = illegal;
          gnt_next[win_idx] = 1'b1;
          err_next          = illegal;
          // Illegal accesses never touch the register file bus.
          if (!illegal) begin
            rf_addr_next = addr_slice[win_idx];
            if (bus.wr[win_idx]) begin
              rf_wen_next = 1'b1;
              rf_din_next = wdata_slice[win_idx];
            end else begin
              rf_oen_next = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        state_next = wr_reg ? IDLE : RWAIT;
      end
      RWAIT: begin
        rdata_next           = ill_reg ? '0 : bus.rf_dout;
        rvalid_next[win_reg] = 1'b1;
        state_next           = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      last_reg    <= IW'(NREQ - 1);
      win_reg     <= '0;
      wr_reg      <= 1'b0;
      ill_reg     <= 1'b0;
      gnt_reg     <= '0;
      rvalid_reg  <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      rf_wen_reg  <= 1'b0;
      rf_oen_reg  <= 1'b0;
      rf_addr_reg <= '0;
      rf_din_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      win_reg     <= win_next;
      wr_reg      <= wr_next;
      ill_reg     <= ill_next;
      gnt_reg     <= gnt_next;
      rvalid_reg  <= rvalid_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      rf_wen_reg  <= rf_wen_next;
      rf_oen_reg  <= rf_oen_next;
      rf_addr_reg <= rf_addr_next;
      rf_din_reg  <= rf_din_next;
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.err     = err_reg;
  assign bus.rf_wen  = rf_wen_reg;
  assign bus.rf_oen  = rf_oen_reg;
  assign bus.rf_addr = rf_addr_reg;
  assign bus.rf_din  = rf_din_reg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: per-requester op queues drive the DUT, a transaction-level
// model predicts grants and read data into queues, and a negedge monitor compares.
module tb_regfile_arbiter;
  localparam int NREQ  = 4;
  localparam int NREGS = 7;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rf_clr = 1'b1;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file: write on rf_wen, registered read one cycle after rf_oen.
  logic [DW-1:0] rf_mem [8];
  logic [DW-1:0] rf_dout_q;
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
      rf_dout_q <= '0;
    end else begin
      if (bus.rf_wen) rf_mem[bus.rf_addr] <= bus.rf_din;
      if (bus.rf_oen) rf_dout_q <= rf_mem[bus.rf_addr];
    end
  end
  assign bus.rf_dout = rf_dout_q;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] gnt;
    bit              err;
    bit              wen;
    bit              oen;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   din;
  } gexp_t;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] rv;
    logic [DW-1:0]   rdata;
  } rexp_t;

  op_t   opq [NREQ][$];
  gexp_t gq [$];
  rexp_t rq [$];

  logic [DW-1:0] ref_regs [NREGS];
  int            m_last = NREQ - 1;
  int            m_busy = 0;
  int            pend_pop = -1;
  int            cyc = 0;
  int            checks = 0;
  int            passes = 0;
  logic [DW-1:0] hold = '0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: pops the model's predictions whenever the DUT presents a grant or read data.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rf_wen_oen_exclusive", {31'd0, bus.rf_wen & bus.rf_oen}, 32'd0);
      if (bus.gnt !== '0) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", {28'd0, bus.gnt}, 32'd0);
        end else begin
          gexp_t g;
          g = gq.pop_front();
          chk("gnt_cycle", cyc, g.cyc);
          chk("gnt", {28'd0, bus.gnt}, {28'd0, g.gnt});
          chk("err", {31'd0, bus.err}, {31'd0, g.err});
          chk("rf_wen", {31'd0, bus.rf_wen}, {31'd0, g.wen});
          chk("rf_oen", {31'd0, bus.rf_oen}, {31'd0, g.oen});
          if (g.wen || g.oen) chk("rf_addr", {29'd0, bus.rf_addr}, {29'd0, g.addr});
          if (g.wen) chk("rf_din", {24'd0, bus.rf_din}, {24'd0, g.din});
          $display("gnt  cyc=%0d gnt=%b err=%0d wen=%0d oen=%0d addr=%0d din=%02h",
                   cyc, bus.gnt, bus.err, bus.rf_wen, bus.rf_oen, bus.rf_addr, bus.rf_din);
        end
      end else begin
        chk("idle_ctl", {29'd0, bus.err, bus.rf_wen, bus.rf_oen}, 32'd0);
      end
      if (bus.rvalid !== '0) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", {28'd0, bus.rvalid}, 32'd0);
        end else begin
          rexp_t r;
          r = rq.pop_front();
          chk("rvalid_cycle", cyc, r.cyc);
          chk("rvalid", {28'd0, bus.rvalid}, {28'd0, r.rv});
          chk("rdata", {24'd0, bus.rdata}, {24'd0, r.rdata});
          hold = r.rdata;
          $display("read cyc=%0d rvalid=%b rdata=%02h", cyc, bus.rvalid, bus.rdata);
        end
      end else begin
        chk("rdata_hold", {24'd0, bus.rdata}, {24'd0, hold});
      end
    end
  end

  task automatic drive_inputs();
    logic [NREQ-1:0]    rv, wv;
    logic [NREQ*AW-1:0] av;
    logic [NREQ*DW-1:0] dv;
    rv = '0; wv = '0; av = '0; dv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (opq[i].size() > 0) begin
        rv[i] = 1'b1;
        wv[i] = opq[i][0].wr;
        av[i*AW +: AW] = opq[i][0].addr;
        dv[i*DW +: DW] = opq[i][0].wdata;
      end
    end
    bus.req = rv; bus.wr = wv; bus.addr = av; bus.wdata = dv;
  endtask

  // One cycle of stimulus; the model decides what the DUT must do at the coming edge.
  task automatic step();
    if (pend_pop >= 0) begin
      void'(opq[pend_pop].pop_front());
      pend_pop = -1;
    end
    drive_inputs();
    if (m_busy > 0) begin
      m_busy--;
    end else begin
      int w;
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && opq[(m_last + k) % NREQ].size() > 0) w = (m_last + k) % NREQ;
      if (w >= 0) begin
        op_t   op;
        gexp_t g;
        rexp_t r;
        bit    legal;
        op     = opq[w][0];
        legal  = (int'(op.addr) < NREGS);
        g.cyc  = cyc + 1;
        g.gnt  = NREQ'(1) << w;
        g.err  = !legal;
        g.wen  = legal && op.wr;
        g.oen  = legal && !op.wr;
        g.addr = op.addr;
        g.din  = op.wdata;
        gq.push_back(g);
        if (op.wr) begin
          if (legal) ref_regs[op.addr] = op.wdata;
          m_busy = 1;
        end else begin
          r.cyc   = cyc + 3;
          r.rv    = NREQ'(1) << w;
          r.rdata = legal ? ref_regs[op.addr] : '0;
          rq.push_back(r);
          m_busy = 2;
        end
        m_last   = w;
        pend_pop = w;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    gq.delete();
    rq.delete();
    m_last = NREQ - 1;
    m_busy = 0;
    hold = '0;
  endtask

  task automatic chk_zero();
    @(negedge clk);
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_rvalid", {28'd0, bus.rvalid}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    chk("rst_rf_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rst_rf_oen", {31'd0, bus.rf_oen}, 32'd0);
    chk("rst_rf_addr", {29'd0, bus.rf_addr}, 32'd0);
    chk("rst_rf_din", {24'd0, bus.rf_din}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_op(int r, bit wr, int a, int d);
    op_t op;
    op.wr = wr; op.addr = AW'(a); op.wdata = DW'(d);
    opq[r].push_back(op);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 2000 && (m_busy > 0 || pend_pop >= 0 || opq[0].size() > 0 ||
           opq[1].size() > 0 || opq[2].size() > 0 || opq[3].size() > 0)) begin
      step();
      n++;
    end
    chk("drain_timeout", {31'd0, n >= 2000}, 32'd0);
    repeat (4) step();
  endtask

  initial begin
    bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < NREGS; i++) ref_regs[i] = '0;

    do_reset(2);
    rf_clr = 1'b0;
    chk_zero();
    mon_en = 1'b1;
    repeat (10) step();

    // Write then read back through requester 0.
    push_op(0, 1, 5, 8'hA5);
    push_op(0, 0, 5, 0);
    drain();

    // Lone requester 3: back-to-back writes of every register, then readback.
    for (int a = 0; a < NREGS; a++) push_op(3, 1, a, $urandom_range(0, 255));
    for (int a = 0; a < NREGS; a++) push_op(3, 0, a, 0);
    drain();

    // Illegal address write and read.
    push_op(2, 1, 7, 8'hFF);
    push_op(2, 0, 7, 0);
    drain();

    // Fairness from a fresh pointer: expect 0,1,2,3,0.
    do_reset(1);
    chk_zero();
    push_op(0, 0, 0, 0);
    push_op(0, 0, 0, 0);
    for (int i = 1; i < NREQ; i++) push_op(i, 0, i, 0);
    drain();

    // Reset in the RWAIT cycle of a read from requester 1.
    push_op(1, 0, 4, 0);
    step();
    step();
    do_reset(1);
    chk_zero();
    push_op(1, 0, 5, 0);
    push_op(3, 0, 6, 0);
    drain();

    // Randomized traffic.
    for (int b = 0; b < 8; b++) begin
      int nops;
      nops = $urandom_range(3, 12);
      for (int j = 0; j < nops; j++)
        push_op($urandom_range(0, NREQ - 1), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), $urandom_range(0, 255));
      drain();
      repeat ($urandom_range(0, 3)) step();
    end

    chk("gnt_queue_empty", gq.size(), 32'd0);
    chk("rvalid_queue_empty", rq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single-port 8-bit register file bus among NREQ requesters.
- Accepts one read or write request at a time. Drives the register file's write-enable, output-enable, address and data-in lines, and returns read data to the winning requester.
- Sits between the requesters (datapath/control units) and the register file. It is the only driver of the register file bus.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NREGS, 7, number of implemented registers; addresses >= NREGS are illegal.
- AW, 3, register address width.
- DW, 8, data width.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  synchronous active-high reset.
- REQ  in  NREQ  per-requester request, level; held until GNT seen.
- WR  in  NREQ  per-requester op: 1 = write, 0 = read; valid with REQ.
- ADDR  in  NREQ*AW  flattened per-requester address; slice i = [i*AW +: AW].
- WDATA  in  NREQ*DW  flattened per-requester write data.
- GNT  out  NREQ  one-hot grant pulse, one cycle.
- RVALID  out  NREQ  one-hot read-data-valid pulse, one cycle.
- RDATA  out  DW  read data, valid when any RVALID bit is high.
- ERR  out  1  one-cycle pulse with GNT when the granted ADDR >= NREGS.
- RF_WEN  out  1  register file write enable.
- RF_OEN  out  1  register file output enable.
- RF_ADDR  out  AW  register file address.
- RF_DIN  out  DW  register file write data.
- RF_DOUT  in  DW  register file read data; registered in the file, valid 1 cycle after RF_OEN.

Behaviour:
- All outputs are registered.
- Reset: state = IDLE; GNT, RVALID, ERR, RF_WEN, RF_OEN = 0; RDATA, RF_ADDR, RF_DIN = 0; round-robin pointer LAST = NREQ-1, so requester 0 wins first.
- RST is sampled every edge and dominates everything. A reset mid-operation aborts it: no RVALID is issued, and an in-flight read is discarded.
- FSM states: IDLE, ISSUE, RWAIT.
- IDLE, REQ == 0: stay in IDLE.
- IDLE, REQ != 0 at edge E0:
  - Winner = first set REQ bit searching LAST+1, LAST+2, ... mod NREQ.
  - Latch WR, ADDR and WDATA of the winner; LAST <= winner.
  - In cycle 1 (after E0): GNT[winner] = 1, state = ISSUE.
  - Legal write: RF_WEN = 1, RF_ADDR/RF_DIN = latched values.
  - Legal read: RF_OEN = 1, RF_ADDR = latched address.
- ISSUE → IDLE (write) or RWAIT (read), after exactly one cycle. RF_WEN, RF_OEN and GNT drop to 0.
- RWAIT: at the end of cycle 2, RDATA <= RF_DOUT and RVALID[winner] <= 1 for cycle 3; state -> IDLE.
- RF_OEN is never high in the same cycle as RF_WEN.
- Latencies from REQ sampled at E0:
  - GNT in cycle 1.
  - Write committed at end of cycle 1.
  - Read data in cycle 3.
- Throughput: next arbitration at the end of cycle 2 (write) or cycle 3 (read).
- Requester rules:
  - Hold REQ, WR, ADDR and WDATA stable until GNT.
  - Deassert REQ (or present the next request) in the cycle after GNT.
  - REQ still high in IDLE is treated as a new request.
- Illegal address (ADDR >= NREGS):
  - GNT and ERR pulse in cycle 1; RF_WEN and RF_OEN stay 0.
  - Write is dropped.
  - Read still goes through RWAIT and returns RDATA = 0 with RVALID in cycle 3.
- The pointer advances only on a grant, so a lone requester is granted back-to-back. With all requesters active, the grant order is 0,1,2,...,NREQ-1,0.
- RDATA holds its last value between RVALID pulses.

Test Plan:
- Reset then idle: RST high 2 cycles, REQ = 0 -> all outputs 0, no GNT for 10 cycles.
- Write/read same requester: REQ[0] write ADDR = 5, WDATA = 0xA5; then read ADDR = 5 -> GNT[0] cycle 1 with RF_WEN = 1, RF_ADDR = 5, RF_DIN = 0xA5; read RVALID[0] cycle 3 with RDATA = 0xA5.
- Fairness: all 4 REQ held high as reads of ADDR = i -> grants 0,1,2,3,0 in order, one per 3 cycles; each RVALID[i] carries the register i value.
- Illegal address: REQ[2] write ADDR = 7, WDATA = 0xFF -> GNT[2] and ERR = 1, RF_WEN = 0; subsequent read of 7 -> RVALID[2], RDATA = 0x00, ERR = 1.
- Reset mid-read: REQ[1] read granted, RST asserted in RWAIT cycle -> no RVALID; after reset, REQ[1] and REQ[3] together -> GNT[1] first (LAST = 3).
- Back-to-back writes: REQ[3] alone, writes to ADDR 0..6 -> GNT[3] every 2 cycles, RF_WEN pulses on alternating cycles, register contents verified by readback.
